// File: rtl/trojan7_pkg.sv
// Shared types and default constants for the trojan7 slave-select decoder.
// Holds the trigger FSM state encoding and the key/mask/length defaults.
package trojan7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S1     = 2'd1,
    S2     = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  localparam logic [31:0] TRIG_ADDR_DEF    = 32'h4000_0F00;
  localparam logic [31:0] TRIG_DATA_DEF    = 32'hA5A5_5A5A;
  localparam logic [31:0] TRIG_S0_DEF      = 32'h0707_0707;
  localparam logic [3:0]  PAYLOAD_MASK_DEF = 4'b1010;
  localparam int          PAYLOAD_LEN_DEF  = 16;

  // Payload counter width, never narrower than one bit.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/trojan7_if.sv
// Bus-side signals seen by the decoder: address/data/slave-0 read data in, select out.
// No handshake; every field is sampled or driven once per clock.
interface trojan7_if;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] s0_data_i;
  logic [3:0]  slv_sel;

  modport master (output wb_addr_i, output wb_data_i, output s0_data_i, input slv_sel);
  modport slave  (input wb_addr_i, input wb_data_i, input s0_data_i, output slv_sel);
endinterface

// File: rtl/trojan7_trigger.sv
// Three-step key-sequence FSM with a bounded payload counter; asserts active while armed.
// active follows state with no extra latency; inputs have no backpressure.
import trojan7_pkg::*;

module trojan7_trigger #(
  parameter logic [31:0] TRIG_ADDR   = TRIG_ADDR_DEF,
  parameter logic [31:0] TRIG_DATA   = TRIG_DATA_DEF,
  parameter logic [31:0] TRIG_S0     = TRIG_S0_DEF,
  parameter int          PAYLOAD_LEN = PAYLOAD_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] s0_data_i,
  output logic        active
);

  localparam int            CW       = cnt_width(PAYLOAD_LEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PAYLOAD_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          addr_hit, data_hit, s0_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    addr_hit = (wb_addr_i == TRIG_ADDR);
    data_hit = (wb_data_i == TRIG_DATA);
    s0_hit   = (s0_data_i == TRIG_S0);
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (addr_hit) state_d = S1;
      end
      // Data key wins over a repeated address key.
      S1: begin
        if (data_hit)      state_d = S2;
        else if (addr_hit) state_d = S1;
        else               state_d = IDLE;
      end
      S2: begin
        if (s0_hit) begin
          state_d = ACTIVE;
          cnt_d   = CNT_LOAD;
        end else if (addr_hit) begin
          state_d = S1;
        end else begin
          state_d = IDLE;
        end
      end
      // Keys are ignored here, so the payload can never be extended.
      ACTIVE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == ACTIVE);
  end

endmodule

// File: rtl/trojan7.sv
// Registered slave-select decoder; XORs a mask into the select while the trigger is active.
// slv_sel follows wb_addr_i[31:28] by 1 cycle; no backpressure.
import trojan7_pkg::*;

module trojan7 #(
  parameter logic [31:0] TRIG_ADDR    = TRIG_ADDR_DEF,
  parameter logic [31:0] TRIG_DATA    = TRIG_DATA_DEF,
  parameter logic [31:0] TRIG_S0      = TRIG_S0_DEF,
  parameter logic [3:0]  PAYLOAD_MASK = PAYLOAD_MASK_DEF,
  parameter int          PAYLOAD_LEN  = PAYLOAD_LEN_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  trojan7_if.slave bus
);

  logic       active;
  logic [3:0] slv_sel_q, slv_sel_d;

  trojan7_trigger #(
    .TRIG_ADDR   (TRIG_ADDR),
    .TRIG_DATA   (TRIG_DATA),
    .TRIG_S0     (TRIG_S0),
    .PAYLOAD_LEN (PAYLOAD_LEN)
  ) u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_addr_i (bus.wb_addr_i),
    .wb_data_i (bus.wb_data_i),
    .s0_data_i (bus.s0_data_i),
    .active    (active)
  );

  always_comb begin
    slv_sel_d = bus.wb_addr_i[31:28] ^ (active ? PAYLOAD_MASK : 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slv_sel_q <= 4'h0;
    else        slv_sel_q <= slv_sel_d;
  end

  assign bus.slv_sel = slv_sel_q;

endmodule

// File: tb/tb_trojan7.sv
// Directed bench for trojan7: driver queues hand-computed slv_sel values, monitor checks them.
import trojan7_pkg::*;

module tb_trojan7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  trojan7_if bus ();

  trojan7 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  logic [3:0] mon_e;
  string      mon_t;

  // Inputs change at negedge; the edge after that produces one expected slv_sel.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s,
                      input logic r, input logic [3:0] e, input string tag);
    @(negedge clk);
    bus.wb_addr_i = a;
    bus.wb_data_i = d;
    bus.s0_data_i = s;
    rst_n = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fire(input logic [3:0] nib);
    step(TRIG_ADDR_DEF, 32'h0, 32'h0, 1'b1, 4'h4, "key_addr");
    step({nib, 28'h0}, TRIG_DATA_DEF, 32'h0, 1'b1, nib, "key_data");
    step({nib, 28'h0}, 32'h0, TRIG_S0_DEF, 1'b1, nib, "key_s0");
  endtask

  task automatic hold(input logic [3:0] nib, input logic [3:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) step({nib, 28'h0}, 32'h0, 32'h0, 1'b1, e, tag);
  endtask

  // Monitor: compare one queued expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (bus.slv_sel !== mon_e) begin
        failures++;
        $display("FAIL %s: slv_sel=%h expected=%h at %0t", mon_t, bus.slv_sel, mon_e, $time);
      end
    end
  end

  initial begin
    bus.wb_addr_i = 32'h0;
    bus.wb_data_i = 32'h0;
    bus.s0_data_i = 32'h0;

    // Reset dominates a nonzero address.
    step(32'h7000_0000, 32'h0, 32'h0, 1'b0, 4'h0, "reset0");
    step(32'h7000_0000, 32'h0, 32'h0, 1'b0, 4'h0, "reset1");
    step(32'h3000_0000, 32'h0, 32'h0, 1'b1, 4'h3, "decode3");
    for (int n = 0; n < 16; n++) step({n[3:0], 28'h123_4567}, 32'h0, 32'h0, 1'b1, n[3:0], "sweep");

    // Full trigger: 16 cycles of 5^A=F, then back to 5.
    fire(4'h5);
    hold(4'h5, 4'hF, 16, "full_masked");
    hold(4'h5, 4'h5, 3, "full_after");

    // Broken sequence: wrong data drops back to IDLE, s0 key then does nothing.
    step(TRIG_ADDR_DEF, 32'h0, 32'h0, 1'b1, 4'h4, "brk_addr");
    step(32'h5000_0000, 32'h0, 32'h0, 1'b1, 4'h5, "brk_data");
    step(32'h5000_0000, 32'h0, TRIG_S0_DEF, 1'b1, 4'h5, "brk_s0");
    hold(4'h5, 4'h5, 4, "brk_after");

    // Re-arm: address key in S2 returns to S1, then data+s0 keys fire; 6^A=C.
    step(TRIG_ADDR_DEF, 32'h0, 32'h0, 1'b1, 4'h4, "rearm_addr");
    step(32'h5000_0000, TRIG_DATA_DEF, 32'h0, 1'b1, 4'h5, "rearm_data");
    step(TRIG_ADDR_DEF, 32'h0, 32'h0, 1'b1, 4'h4, "rearm_addr2");
    step(32'h6000_0000, TRIG_DATA_DEF, 32'h0, 1'b1, 4'h6, "rearm_data2");
    step(32'h6000_0000, 32'h0, TRIG_S0_DEF, 1'b1, 4'h6, "rearm_s0");
    hold(4'h6, 4'hC, 16, "rearm_masked");
    hold(4'h6, 4'h6, 2, "rearm_after");

    // Reset after 5 masked cycles aborts the payload.
    fire(4'h5);
    hold(4'h5, 4'hF, 5, "rst_masked");
    step(32'h5000_0000, 32'h0, 32'h0, 1'b0, 4'h0, "rst_mid");
    hold(4'h5, 4'h5, 6, "rst_after");

    // Keys repeated while ACTIVE neither retrigger nor extend; 4^A=E on the address key.
    fire(4'h5);
    hold(4'h5, 4'hF, 1, "act_masked");
    step(TRIG_ADDR_DEF, 32'h0, 32'h0, 1'b1, 4'hE, "act_addr");
    step(32'h5000_0000, TRIG_DATA_DEF, 32'h0, 1'b1, 4'hF, "act_data");
    step(32'h5000_0000, 32'h0, TRIG_S0_DEF, 1'b1, 4'hF, "act_s0");
    hold(4'h5, 4'hF, 12, "act_masked_rest");
    hold(4'h5, 4'h5, 1, "act_end");

    // New sequence straight after return to IDLE.
    fire(4'h9);
    hold(4'h9, 4'h3, 16, "again_masked");
    hold(4'h9, 4'h9, 2, "again_after");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
